// File: rtl/rom_read_arbiter.sv
// -----------------------------------------------------------------------------
// rom_read_arbiter
//
// Shares one combinational ROM (read, addr -> data_out) among NREQ requesters.
// A pending request is selected in IDLE, its address is latched onto the ROM
// address lines, the returned word is captured one cycle later and handed back
// with a one-hot rvalid pulse to the winning requester.
//
// Transaction timeline (grant edge E):
//   E..E+1   : gnt[win]=1, rom_read=1, rom_addr=latched address   (READ)
//   E+1..E+2 : rvalid[win]=1, rdata=captured word                  (RESP)
//   E+3      : earliest next grant
//
// Configuration macro:
//   ROM_ARB_FIXED_PRIO_EN - when defined, the lowest set req index always
//                           wins; otherwise round-robin from pointer ptr.
//
// Parameters:
//   WIDTH  - ROM data width
//   DEPTH  - ROM word count (DEPTH <= 2**NUMBER)
//   NUMBER - ROM address width
//   NREQ   - number of requesters (2..8)
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   req      - per-requester request level
//   addr_in  - per-requester address, requester i at [i*NUMBER +: NUMBER]
//   gnt      - one-hot grant, held across READ and RESP
//   rvalid   - one-hot single-cycle pulse marking rdata valid
//   rdata    - registered read data, held until the next capture
//   busy     - high whenever the FSM is not idle
//   rom_read - registered ROM read enable
//   rom_addr - registered ROM address
//   rom_data - ROM data output (combinational from rom_addr)
// -----------------------------------------------------------------------------
module rom_read_arbiter #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned NUMBER = 3,
  parameter int unsigned NREQ   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*NUMBER-1:0]   addr_in,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [WIDTH-1:0]         rdata,
  output logic                     busy,
  output logic                     rom_read,
  output logic [NUMBER-1:0]        rom_addr,
  input  logic [WIDTH-1:0]         rom_data
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StResp
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_rvalid;
  logic [WIDTH-1:0]  r_rdata;
  logic              r_rom_read;
  logic [NUMBER-1:0] r_rom_addr;

  logic              w_any;
  logic [PtrW-1:0]   w_win_idx;
  logic [NREQ-1:0]   w_win_oh;
  logic [NUMBER-1:0] w_addr_sel;
  logic              w_addr_ok;
  logic [WIDTH-1:0]  w_rd_word;

  // (base + off) mod NREQ, for base < NREQ and off < NREQ
  function automatic logic [PtrW-1:0] wrap_idx(input int unsigned base, input int unsigned off);
    int unsigned sum;
    sum = base + off;
    if (sum >= NREQ) begin
      sum = sum - NREQ;
    end
    return PtrW'(sum);
  endfunction

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
`ifdef ROM_ARB_FIXED_PRIO_EN
  always_comb begin
    w_any     = |req;
    w_win_idx = '0;
    // Descending scan so the lowest set index is the last to be written.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_win_idx = PtrW'(i);
      end
    end
  end
`else
  logic [PtrW-1:0] r_ptr;
  logic [PtrW-1:0] w_ptr_nxt;

  always_comb begin
    w_any     = 1'b0;
    w_win_idx = '0;
    // Search upward from the pointer, wrapping; first set bit wins.
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!w_any && req[wrap_idx(int'(r_ptr), k)]) begin
        w_any     = 1'b1;
        w_win_idx = wrap_idx(int'(r_ptr), k);
      end
    end
    w_ptr_nxt = wrap_idx(int'(w_win_idx), 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (r_state == StIdle && w_any) begin
      r_ptr <= w_ptr_nxt;
    end
  end
`endif

  always_comb begin
    w_win_oh            = '0;
    w_win_oh[w_win_idx] = w_any;
  end

  assign w_addr_sel = addr_in[w_win_idx*NUMBER +: NUMBER];

  // Out-of-range addresses still perform the read but return zero.
  assign w_addr_ok = (32'(r_rom_addr) < 32'(DEPTH));
  assign w_rd_word = (w_addr_ok && r_rom_read) ? rom_data : '0;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  w_state_nxt = w_any ? StRead : StIdle;
      StRead:  w_state_nxt = StResp;
      StResp:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered datapath driven by the current state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt      <= '0;
      r_rvalid   <= '0;
      r_rdata    <= '0;
      r_rom_read <= 1'b0;
      r_rom_addr <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            r_gnt      <= w_win_oh;
            r_rom_addr <= w_addr_sel;
            r_rom_read <= 1'b1;
          end
        end
        StRead: begin
          r_rdata    <= w_rd_word;
          r_rvalid   <= r_gnt;
          r_rom_read <= 1'b0;
        end
        StResp: begin
          r_rvalid   <= '0;
          r_gnt      <= '0;
          r_rom_addr <= '0;
        end
        default: begin
          r_gnt      <= '0;
          r_rvalid   <= '0;
          r_rom_read <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt      = r_gnt;
    rvalid   = r_rvalid;
    rdata    = r_rdata;
    rom_read = r_rom_read;
    rom_addr = r_rom_addr;
    busy     = (r_state != StIdle);
  end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom_read_arbiter
//
// Directed self-checking bench. Main instance uses WIDTH=8, DEPTH=8, NUMBER=3,
// NREQ=4 against a combinational ROM with mem[a] = 8'hA0 + a. A second
// instance with DEPTH=6, NREQ=2 exercises the out-of-range address rule.
// Honours ROM_ARB_FIXED_PRIO_EN for the arbitration-order expectations.
// -----------------------------------------------------------------------------
module tb_rom_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  logic [3:0]  req;
  logic [11:0] addr_in;
  logic [3:0]  gnt;
  logic [3:0]  rvalid;
  logic [7:0]  rdata;
  logic        busy;
  logic        rom_read;
  logic [2:0]  rom_addr;
  logic [7:0]  rom_data;

  logic [1:0]  req_b;
  logic [5:0]  addr_in_b;
  logic [1:0]  gnt_b;
  logic [1:0]  rvalid_b;
  logic [7:0]  rdata_b;
  logic        busy_b;
  logic        rom_read_b;
  logic [2:0]  rom_addr_b;
  logic [7:0]  rom_data_b;

  logic [7:0]  mem [8];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign rom_data   = mem[rom_addr];
  assign rom_data_b = mem[rom_addr_b];

  rom_read_arbiter #(
    .WIDTH (8),
    .DEPTH (8),
    .NUMBER(3),
    .NREQ  (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .addr_in (addr_in),
    .gnt     (gnt),
    .rvalid  (rvalid),
    .rdata   (rdata),
    .busy    (busy),
    .rom_read(rom_read),
    .rom_addr(rom_addr),
    .rom_data(rom_data)
  );

  rom_read_arbiter #(
    .WIDTH (8),
    .DEPTH (6),
    .NUMBER(3),
    .NREQ  (2)
  ) dut_b (
    .clk     (clk),
    .rst     (rst),
    .req     (req_b),
    .addr_in (addr_in_b),
    .gnt     (gnt_b),
    .rvalid  (rvalid_b),
    .rdata   (rdata_b),
    .busy    (busy_b),
    .rom_read(rom_read_b),
    .rom_addr(rom_addr_b),
    .rom_data(rom_data_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".gnt"},      32'(gnt),      32'h0);
    chk({tag, ".rvalid"},   32'(rvalid),   32'h0);
    chk({tag, ".busy"},     32'(busy),     32'h0);
    chk({tag, ".rom_read"}, 32'(rom_read), 32'h0);
  endtask

  int          exp_win;
  logic [3:0]  exp_oh;

  initial begin
    for (int a = 0; a < 8; a++) begin
      mem[a] = 8'hA0 + 8'(a);
    end
    rst       = 1'b1;
    req       = '0;
    addr_in   = '0;
    req_b     = '0;
    addr_in_b = '0;

    // Reset values
    step();
    chk_zero("reset");
    chk("reset.rdata",    32'(rdata),    32'h0);
    chk("reset.rom_addr", 32'(rom_addr), 32'h0);
    chk("reset.b_busy",   32'(busy_b),   32'h0);
    rst = 1'b0;

    // Single read: requester 1, address 5
    req            = 4'b0010;
    addr_in[3 +: 3] = 3'd5;
    step();
    chk("single.gnt",      32'(gnt),      32'h2);
    chk("single.rom_read", 32'(rom_read), 32'h1);
    chk("single.rom_addr", 32'(rom_addr), 32'h5);
    chk("single.busy1",    32'(busy),     32'h1);
    chk("single.rvalid0",  32'(rvalid),   32'h0);
    step();
    chk("single.rvalid",   32'(rvalid),   32'h2);
    chk("single.rdata",    32'(rdata),    32'hA5);
    chk("single.rd_low",   32'(rom_read), 32'h0);
    chk("single.gnt_hold", 32'(gnt),      32'h2);
    chk("single.busy2",    32'(busy),     32'h1);
    req = '0;
    step();
    chk_zero("single.done");
    chk("single.rdata_hold", 32'(rdata), 32'hA5);
    step();
    chk_zero("single.idle");

    // Reset during READ: requester 2, address 6 (ptr is 2 here in round-robin)
    req             = 4'b0100;
    addr_in[6 +: 3] = 3'd6;
    step();
    chk("rstrd.gnt",      32'(gnt),      32'h4);
    chk("rstrd.rom_read", 32'(rom_read), 32'h1);
    #2 rst = 1'b1;
    #2;
    chk_zero("rstrd.async");
    chk("rstrd.rdata",    32'(rdata),    32'h0);
    chk("rstrd.rom_addr", 32'(rom_addr), 32'h0);
    #2 rst = 1'b0;
    req = '0;
    step();
    chk_zero("rstrd.dropped");
    chk("rstrd.rdata2", 32'(rdata), 32'h0);

    // Arbitration order with all requesters active; requester i reads i+1.
    // The first grant also shows the pointer was cleared by the reset.
    addr_in = {3'd4, 3'd3, 3'd2, 3'd1};
    req     = 4'b1111;
    for (int t = 0; t < 5; t++) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
      exp_win = 0;
`else
      exp_win = t % 4;
`endif
      exp_oh = 4'b0001 << exp_win;
      step();
      chk($sformatf("rr%0d.gnt", t),      32'(gnt),      32'(exp_oh));
      chk($sformatf("rr%0d.rom_addr", t), 32'(rom_addr), 32'(exp_win + 1));
      step();
      chk($sformatf("rr%0d.rvalid", t),   32'(rvalid),   32'(exp_oh));
      chk($sformatf("rr%0d.rdata", t),    32'(rdata),    32'hA1 + 32'(exp_win));
      req = 4'b1111 & ~exp_oh;
      step();
      chk($sformatf("rr%0d.idle", t),     32'(busy),     32'h0);
      req = 4'b1111;
    end
    req = '0;
    step();
    chk_zero("rr.end");

    // Address sweep on requester 2
    for (int a = 0; a < 8; a++) begin
      req             = 4'b0100;
      addr_in[6 +: 3] = 3'(a);
      step();
      chk($sformatf("sweep%0d.gnt", a),      32'(gnt),      32'h4);
      chk($sformatf("sweep%0d.rom_addr", a), 32'(rom_addr), 32'(a));
      step();
      chk($sformatf("sweep%0d.rvalid", a),   32'(rvalid),   32'h4);
      chk($sformatf("sweep%0d.rdata", a),    32'(rdata),    32'hA0 + 32'(a));
      req = '0;
      step();
      chk($sformatf("sweep%0d.rv_off", a),   32'(rvalid),   32'h0);
    end

    // Input changes during READ are ignored
    addr_in         = '0;
    addr_in[0 +: 3] = 3'd3;
    addr_in[6 +: 3] = 3'd7;
    req             = 4'b0001;
    step();
    chk("ign.gnt0", 32'(gnt), 32'h1);
    req             = 4'b0101;
    addr_in[0 +: 3] = 3'd6;
    step();
    chk("ign.rvalid0",  32'(rvalid), 32'h1);
    chk("ign.rdata0",   32'(rdata),  32'hA3);
    chk("ign.gnt_hold", 32'(gnt),    32'h1);
    req = 4'b0100;
    step();
    chk_zero("ign.idle");
    step();
    chk("ign.gnt2",      32'(gnt),      32'h4);
    chk("ign.rom_addr2", 32'(rom_addr), 32'h7);
    step();
    chk("ign.rvalid2",   32'(rvalid),   32'h4);
    chk("ign.rdata2",    32'(rdata),    32'hA7);
    req = '0;
    step();
    chk_zero("ign.end");

    // Out-of-range address on the DEPTH=6 instance
    req_b           = 2'b01;
    addr_in_b[2:0]  = 3'd7;
    step();
    chk("oor.gnt",      32'(gnt_b),      32'h1);
    chk("oor.rom_read", 32'(rom_read_b), 32'h1);
    step();
    chk("oor.rvalid",   32'(rvalid_b),   32'h1);
    chk("oor.rdata",    32'(rdata_b),    32'h0);
    req_b = '0;
    step();
    chk("oor.idle",     32'(busy_b),     32'h0);
    req_b           = 2'b10;
    addr_in_b[5:3]  = 3'd5;
    step();
    chk("inr.gnt",      32'(gnt_b),      32'h2);
    step();
    chk("inr.rvalid",   32'(rvalid_b),   32'h2);
    chk("inr.rdata",    32'(rdata_b),    32'hA5);
    req_b = '0;
    step();
    chk("inr.idle",     32'(busy_b),     32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_read_arbiter.md
# rom_read_arbiter

Synchronous arbiter that shares one combinational `rom` instance (read-enable, address in, data out) among NREQ requesters. It selects one pending request, drives the ROM read and address lines from registers, captures the returned word, and returns it with a one-hot valid to the winning requester. It sits between the ROM and the client blocks and is the only driver of the ROM's `read` and `addr` inputs.

## Interface
- WIDTH, 8, ROM data width in bits
- DEPTH, 8, ROM word count
- NUMBER, 3, ROM address width; DEPTH <= 2**NUMBER
- NREQ, 4, number of requesters; 2..8
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- req  input  NREQ  per-requester request level
- addr_in  input  NREQ*NUMBER  per-requester address; requester i uses bits [i*NUMBER +: NUMBER]
- gnt  output  NREQ  one-hot grant, held for the whole transaction
- rvalid  output  NREQ  one-hot, one-cycle pulse; rdata valid for that requester
- rdata  output  WIDTH  registered read data
- busy  output  1  high whenever state is not IDLE
- rom_read  output  1  to ROM `read`, registered
- rom_addr  output  NUMBER  to ROM `addr`, registered
- rom_data  input  WIDTH  from ROM `data_out`; combinational from rom_addr while rom_read=1

## Operation
- States: IDLE, READ, RESP.
- IDLE: if any req bit is high, pick a winner, latch its addr_in into rom_addr, set gnt[winner], set rom_read=1, go to READ. If no req bit is high, stay in IDLE with all outputs low.
- READ: rom_read=1 for exactly one cycle. At the closing edge: rdata <= rom_data, rvalid[winner] <= 1, rom_read <= 0, go to RESP.
- RESP: rvalid pulse is high. At the closing edge: rvalid <= 0, gnt <= 0, go to IDLE. rdata holds until the next capture.
- No arbitration occurs in READ or RESP. req changes during these states are ignored. addr_in is sampled only at the IDLE grant edge.
- Requester protocol: hold req until rvalid is observed, then deassert req on the next edge. A req still high in IDLE is treated as a new request.
- Round-robin: pointer ptr (initially 0). Search req from ptr upward, wrapping at NREQ. The first set bit wins. On grant, ptr <= winner+1 mod NREQ.
- Address rule: if the latched address is >= DEPTH, the read still occurs but rdata is forced to 0. The ROM output is not used in that case.
- rom_data is ignored whenever rom_read=0.

## Timing
- Reset values: gnt=0, rvalid=0, rdata=0, busy=0, rom_read=0, rom_addr=0, state=IDLE, ptr=0.
- Latency: req sampled high in IDLE at edge E. Then rom_read and gnt are high in cycle E..E+1. rvalid and rdata are valid in cycle E+1..E+2. The earliest next grant is at edge E+3.
- Peak throughput: one read every 3 cycles.
- Simultaneous requests: exactly one gnt bit and at most one rvalid bit are ever high.
- Reset mid-transaction clears all state immediately. The in-flight read is dropped with no rvalid, and the requester must re-request. ptr returns to 0.
- ptr wrap: with NREQ=4 and winner 3, ptr becomes 0.

## Configuration
- ROM_ARB_FIXED_PRIO_EN defined: fixed priority, where the lowest index among set req bits always wins and ptr is unused (held at 0). Not defined (default): round-robin as described. All other behaviour is identical.

## Test plan
- Use a bench ROM with WIDTH=8, DEPTH=8, NUMBER=3 and mem[a]=8'hA0+a.
- Reset check: assert rst mid-sim -> all outputs 0 asynchronously, before the next clk edge.
- Single read: req=4'b0010, addr1=5 -> gnt=0010 and rom_read=1 one cycle after the sample edge. On the following cycle rvalid=0010 and rdata=8'hA5 for exactly one cycle. busy is high for 2 cycles.
- Round-robin: all four req held high, each dropped after its rvalid and re-raised the next IDLE -> grant order 0,1,2,3,0. With ROM_ARB_FIXED_PRIO_EN defined, the order is 0,0,0,... while req0 keeps re-requesting.
- Address sweep: requester 2 reads addresses 0..7 in turn -> rdata = A0..A7. No rvalid bit other than bit 2 is ever set.
- Reset mid-READ: rst pulsed during READ -> no rvalid, rdata=0, state IDLE. A re-request then completes normally.
- Ignored input change: req2 is raised and addr_in0 is changed while requester 0 is in READ -> rdata reflects the address latched at grant. Requester 2 is granted next.
